// File: rtl/bt656_stream_encoder.sv
// BT.656 transmit encoder: frames upstream YUV422 bytes into lines with FF 00 00 XY
// timing codes, horizontal blanking and vertical-blank lines, with optional interlaced field toggling.
module bt656_stream_encoder #(
    parameter int H_ACTIVE_BYTES = 1440,
    parameter int H_BLANK_BYTES  = 280,
    parameter int ACTIVE_LINES   = 288,
    parameter int VBLANK_LINES   = 24,
    parameter int INTERLACED     = 1
) (
    input  logic       clock_in,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [7:0] pix_data,
    input  logic       pix_valid,
    output logic       pix_ready,
    output logic [7:0] data_out,
    output logic       sav_active,
    output logic       field,
    output logic       underflow
);

    localparam int TOTAL_LINES = VBLANK_LINES + ACTIVE_LINES;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EAV,
        S_HBLANK,
        S_SAV,
        S_ACTIVE
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] byte_cnt_q, byte_cnt_d;
    logic [9:0]  line_q, line_d;
    logic        field_q, field_d;
    logic [7:0]  data_q, data_d;
    logic        sav_active_q, sav_active_d;
    logic        underflow_q, underflow_d;

    logic        vblank;
    logic [7:0]  blank_byte;

    // XY protection bits: {1, F, V, H, V^H, F^H, F^V, F^V^H}
    function automatic logic [7:0] timing_xy(input logic f, input logic v, input logic h);
        return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
    endfunction

    function automatic logic [7:0] code_byte(input logic [1:0] idx, input logic [7:0] xy);
        case (idx)
            2'd0:    return 8'hFF;
            2'd3:    return xy;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] clamp_byte(input logic [7:0] b);
        if (b == 8'h00) return 8'h01;
        if (b == 8'hFF) return 8'hFE;
        return b;
    endfunction

    assign vblank     = (line_q < 10'(VBLANK_LINES));
    assign blank_byte = byte_cnt_q[0] ? 8'h10 : 8'h80;
    assign pix_ready  = (state_q == S_ACTIVE) && !vblank;

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q + 11'd1;
        line_d       = line_q;
        field_d      = field_q;
        data_d       = 8'h10;
        sav_active_d = 1'b0;
        underflow_d  = underflow_q;

        case (state_q)
            S_IDLE: begin
                byte_cnt_d = '0;
                if (enable) begin
                    state_d = S_EAV;
                    line_d  = '0;
                end
            end
            S_EAV: begin
                data_d = code_byte(byte_cnt_q[1:0], timing_xy(field_q, vblank, 1'b1));
                if (byte_cnt_q == 11'd3) begin
                    state_d    = S_HBLANK;
                    byte_cnt_d = '0;
                end
            end
            S_HBLANK: begin
                data_d = blank_byte;
                if (byte_cnt_q == 11'(H_BLANK_BYTES - 1)) begin
                    state_d    = S_SAV;
                    byte_cnt_d = '0;
                end
            end
            S_SAV: begin
                data_d = code_byte(byte_cnt_q[1:0], timing_xy(field_q, vblank, 1'b0));
                if (byte_cnt_q == 11'd3) begin
                    sav_active_d = !vblank;
                    state_d      = S_ACTIVE;
                    byte_cnt_d   = '0;
                end
            end
            S_ACTIVE: begin
                // A starved active slot falls back to the blanking pattern so the stream stays legal
                if (vblank) begin
                    data_d = blank_byte;
                end else if (pix_valid) begin
                    data_d = clamp_byte(pix_data);
                end else begin
                    data_d      = blank_byte;
                    underflow_d = 1'b1;
                end
                if (byte_cnt_q == 11'(H_ACTIVE_BYTES - 1)) begin
                    byte_cnt_d = '0;
                    if (line_q == 10'(TOTAL_LINES - 1)) begin
                        line_d  = '0;
                        field_d = field_q ^ (INTERLACED != 0);
                        state_d = enable ? S_EAV : S_IDLE;
                    end else begin
                        line_d  = line_q + 10'd1;
                        state_d = S_EAV;
                    end
                end
            end
            default: begin
                state_d    = S_IDLE;
                byte_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            byte_cnt_q   <= '0;
            line_q       <= '0;
            field_q      <= 1'b0;
            data_q       <= 8'h10;
            sav_active_q <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            line_q       <= line_d;
            field_q      <= field_d;
            data_q       <= data_d;
            sav_active_q <= sav_active_d;
            underflow_q  <= underflow_d;
        end
    end

    assign data_out   = data_q;
    assign sav_active = sav_active_q;
    assign field      = field_q;
    assign underflow  = underflow_q;

endmodule

// File: tb/tb_bt656_stream_encoder.sv
// Directed bench for bt656_stream_encoder using a tiny 20-byte line, 3-line field geometry.
module tb_bt656_stream_encoder;

    logic       clock_in;
    logic       reset_n;
    logic       enable;
    logic [7:0] pix_data;
    logic       pix_valid;
    logic       pix_ready;
    logic [7:0] data_out;
    logic       sav_active;
    logic       field;
    logic       underflow;

    int checks;
    int errors;

    bt656_stream_encoder #(
        .H_ACTIVE_BYTES(8),
        .H_BLANK_BYTES (4),
        .ACTIVE_LINES  (2),
        .VBLANK_LINES  (1),
        .INTERLACED    (1)
    ) dut (
        .clock_in  (clock_in),
        .reset_n   (reset_n),
        .enable    (enable),
        .pix_data  (pix_data),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .data_out  (data_out),
        .sav_active(sav_active),
        .field     (field),
        .underflow (underflow)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    // Inputs change and outputs are sampled 1 time unit after each rising edge
    task automatic step();
        @(posedge clock_in);
        #1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        enable    = 1'b0;
        pix_valid = 1'b0;
        pix_data  = 8'h00;
        repeat (3) step();
        checks++; if (data_out !== 8'h10) begin errors++; $display("[TB] FAIL reset_data: got %h expected 10", data_out); end
        checks++; if (pix_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0", pix_ready); end
        checks++; if (sav_active !== 1'b0) begin errors++; $display("[TB] FAIL reset_sav: got %b expected 0", sav_active); end
        checks++; if (field !== 1'b0) begin errors++; $display("[TB] FAIL reset_field: got %b expected 0", field); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_underflow: got %b expected 0", underflow); end
        reset_n = 1'b1;
        enable  = 1'b1;
        step();
        checks++; if (data_out !== 8'h10) begin errors++; $display("[TB] FAIL idle_to_eav_data: got %h expected 10", data_out); end
    endtask

    task automatic test_vblank_line();
        logic [7:0] exp_b [20];
        exp_b = '{8'hFF, 8'h00, 8'h00, 8'hB6, 8'h80, 8'h10, 8'h80, 8'h10, 8'hFF, 8'h00,
                  8'h00, 8'hAB, 8'h80, 8'h10, 8'h80, 8'h10, 8'h80, 8'h10, 8'h80, 8'h10};
        for (int i = 0; i < 20; i++) begin
            checks++; if (pix_ready !== 1'b0) begin errors++; $display("[TB] FAIL vblank_ready[%0d]: got %b expected 0", i, pix_ready); end
            pix_valid = 1'b0;
            step();
            checks++; if (data_out !== exp_b[i]) begin errors++; $display("[TB] FAIL vblank_data[%0d]: got %h expected %h", i, data_out, exp_b[i]); end
            checks++; if (sav_active !== 1'b0) begin errors++; $display("[TB] FAIL vblank_sav[%0d]: got %b expected 0", i, sav_active); end
        end
        checks++; if (underflow !== 1'b0) begin errors++; $display("[TB] FAIL vblank_underflow: got %b expected 0", underflow); end
    endtask

    task automatic test_active_line();
        logic [7:0] exp_b [20];
        exp_b = '{8'hFF, 8'h00, 8'h00, 8'h9D, 8'h80, 8'h10, 8'h80, 8'h10, 8'hFF, 8'h00,
                  8'h00, 8'h80, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        for (int i = 0; i < 20; i++) begin
            checks++; if (pix_ready !== (i >= 12)) begin errors++; $display("[TB] FAIL active_ready[%0d]: got %b expected %b", i, pix_ready, (i >= 12)); end
            pix_valid = (i >= 12);
            pix_data  = 8'(i - 11);
            step();
            checks++; if (data_out !== exp_b[i]) begin errors++; $display("[TB] FAIL active_data[%0d]: got %h expected %h", i, data_out, exp_b[i]); end
            checks++; if (sav_active !== (i == 11)) begin errors++; $display("[TB] FAIL active_sav[%0d]: got %b expected %b", i, sav_active, (i == 11)); end
        end
        checks++; if (underflow !== 1'b0) begin errors++; $display("[TB] FAIL active_underflow: got %b expected 0", underflow); end
    endtask

    task automatic test_clamp_underflow();
        logic [7:0] din   [8];
        logic       vin   [8];
        logic [7:0] exp_a [8];
        din   = '{8'h00, 8'hFF, 8'h7F, 8'h55, 8'h33, 8'hAA, 8'hFE, 8'h01};
        vin   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        exp_a = '{8'h01, 8'hFE, 8'h7F, 8'h55, 8'h80, 8'hAA, 8'hFE, 8'h01};
        checks++; if (field !== 1'b0) begin errors++; $display("[TB] FAIL field_before_wrap: got %b expected 0", field); end
        for (int i = 0; i < 12; i++) begin
            pix_valid = 1'b0;
            step();
        end
        checks++; if (data_out !== 8'h80) begin errors++; $display("[TB] FAIL line2_sav_xy: got %h expected 80", data_out); end
        for (int i = 0; i < 8; i++) begin
            pix_valid = vin[i];
            pix_data  = din[i];
            step();
            checks++; if (data_out !== exp_a[i]) begin errors++; $display("[TB] FAIL clamp_data[%0d]: got %h expected %h", i, data_out, exp_a[i]); end
            checks++; if (underflow !== (i >= 4)) begin errors++; $display("[TB] FAIL underflow[%0d]: got %b expected %b", i, underflow, (i >= 4)); end
        end
        checks++; if (field !== 1'b1) begin errors++; $display("[TB] FAIL field_after_wrap: got %b expected 1", field); end
    endtask

    task automatic test_field_toggle();
        logic [7:0] exp_b [20];
        exp_b = '{8'hFF, 8'h00, 8'h00, 8'hF1, 8'h80, 8'h10, 8'h80, 8'h10, 8'hFF, 8'h00,
                  8'h00, 8'hEC, 8'h80, 8'h10, 8'h80, 8'h10, 8'h80, 8'h10, 8'h80, 8'h10};
        for (int i = 0; i < 20; i++) begin
            if (i == 5) enable = 1'b0;
            pix_valid = 1'b0;
            step();
            checks++; if (data_out !== exp_b[i]) begin errors++; $display("[TB] FAIL f1_vblank_data[%0d]: got %h expected %h", i, data_out, exp_b[i]); end
        end
        checks++; if (field !== 1'b1) begin errors++; $display("[TB] FAIL f1_field: got %b expected 1", field); end
        checks++; if (underflow !== 1'b1) begin errors++; $display("[TB] FAIL underflow_sticky: got %b expected 1", underflow); end
    endtask

    task automatic test_enable_stop();
        logic [7:0] exp_h [12];
        exp_h = '{8'hFF, 8'h00, 8'h00, 8'hDA, 8'h80, 8'h10, 8'h80, 8'h10, 8'hFF, 8'h00, 8'h00, 8'hC7};
        for (int ln = 0; ln < 2; ln++) begin
            for (int i = 0; i < 20; i++) begin
                logic [7:0] e;
                pix_valid = (i >= 12);
                pix_data  = 8'(8'h11 + 8'(ln * 16) + 8'(i - 12));
                e = (i < 12) ? exp_h[i] : pix_data;
                step();
                checks++; if (data_out !== e) begin errors++; $display("[TB] FAIL f1_active_data[%0d][%0d]: got %h expected %h", ln, i, data_out, e); end
                checks++; if (sav_active !== (i == 11)) begin errors++; $display("[TB] FAIL f1_sav[%0d][%0d]: got %b expected %b", ln, i, sav_active, (i == 11)); end
            end
        end
        checks++; if (pix_ready !== 1'b0) begin errors++; $display("[TB] FAIL idle_ready: got %b expected 0", pix_ready); end
        pix_valid = 1'b0;
        repeat (3) begin
            step();
            checks++; if (data_out !== 8'h10) begin errors++; $display("[TB] FAIL idle_data: got %h expected 10", data_out); end
        end
        checks++; if (field !== 1'b0) begin errors++; $display("[TB] FAIL field_back_to_0: got %b expected 0", field); end
    endtask

    task automatic test_reset_mid_sav();
        logic [7:0] exp_b [10];
        exp_b = '{8'hFF, 8'h00, 8'h00, 8'hB6, 8'h80, 8'h10, 8'h80, 8'h10, 8'hFF, 8'h00};
        enable = 1'b1;
        step();
        for (int i = 0; i < 10; i++) begin
            step();
            checks++; if (data_out !== exp_b[i]) begin errors++; $display("[TB] FAIL restart_data[%0d]: got %h expected %h", i, data_out, exp_b[i]); end
        end
        reset_n = 1'b0;
        step();
        checks++; if (data_out !== 8'h10) begin errors++; $display("[TB] FAIL midsav_data: got %h expected 10", data_out); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("[TB] FAIL midsav_underflow: got %b expected 0", underflow); end
        checks++; if (sav_active !== 1'b0) begin errors++; $display("[TB] FAIL midsav_sav: got %b expected 0", sav_active); end
        checks++; if (pix_ready !== 1'b0) begin errors++; $display("[TB] FAIL midsav_ready: got %b expected 0", pix_ready); end
        reset_n = 1'b1;
        enable  = 1'b0;
        repeat (2) step();
        checks++; if (data_out !== 8'h10) begin errors++; $display("[TB] FAIL post_reset_idle: got %h expected 10", data_out); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_vblank_line();
        test_active_line();
        test_clamp_underflow();
        test_field_toggle();
        test_enable_stop();
        test_reset_mid_sav();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
